source_ram_loader: RTL and testbench



---
 rtl/source_ram_loader.sv | 100 ++++++++++
 tb/tb_source_ram_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/source_ram_loader.sv
// Write-side controller for the 4-bank source RAM array: streams one block of
// 16 packets x 64 words into the banks, packet p -> bank p[1:0], slot p[3:2].
module source_ram_loader #(
  parameter int WPP_LOG2 = 6,
  parameter int NUM_PKT  = 16
) (
  input  logic         ram_clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] ram_data,
  output logic [3:0]   ram_wren,
  output logic [31:0]  ram_address,
  output logic         busy,
  output logic         done,
  output logic         len_err
);

  localparam int PKT_W  = $clog2(NUM_PKT);
  localparam int ADDR_W = PKT_W - 2 + WPP_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q;
  logic [WPP_LOG2-1:0] word_cnt;
  logic [PKT_W-1:0]    pkt_cnt;
  logic [127:0]        data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          wren_q;
  logic                done_q;
  logic                len_err_q;

  logic beat;
  logic word_last;
  logic pkt_last;

  assign in_ready  = (state_q == S_LOAD);
  assign beat      = in_valid && in_ready;
  assign word_last = (word_cnt == {WPP_LOG2{1'b1}});
  assign pkt_last  = (pkt_cnt == PKT_W'(NUM_PKT - 1));

  // NOTE: state and counters use non-blocking assignments so every branch
  // below sees the pre-edge counter values that describe the current beat.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      word_cnt  <= '0;
      pkt_cnt   <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      wren_q    <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      wren_q <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_LOAD;
            word_cnt  <= '0;
            pkt_cnt   <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            wren_q   <= 4'b0001 << pkt_cnt[1:0];
            addr_q   <= {pkt_cnt[PKT_W-1:2], word_cnt};
            data_q   <= in_data;
            word_cnt <= word_cnt + 1'b1;
            // in_last is only audited; the counters alone define framing.
            if (in_last != word_last) len_err_q <= 1'b1;
            if (word_last) begin
              pkt_cnt <= pkt_cnt + 1'b1;
              if (pkt_last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_data    = {4{data_q}};
  assign ram_address = {4{addr_q}};
  assign ram_wren    = wren_q;
  assign busy        = (state_q == S_LOAD);
  assign done        = done_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_source_ram_loader.sv
// Directed bench for source_ram_loader: drives blocks of 1024 words and checks
// the write stream cycle by cycle plus the resulting image in a bank model.
module tb_source_ram_loader;

  logic         ram_clk;
  logic         rst;
  logic         start;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] ram_data;
  logic [3:0]   ram_wren;
  logic [31:0]  ram_address;
  logic         busy;
  logic         done;
  logic         len_err;

  int errors = 0;
  int checks = 0;

  source_ram_loader dut (
    .ram_clk     (ram_clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  // Model of the 4 x 256 x 128-bit array fed by the loader outputs.
  logic [127:0] mem [4][256];
  logic         mem_clr;
  int           wr_count;

  always @(posedge ram_clk) begin
    if (mem_clr) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 256; a++)
          mem[b][a] <= '0;
      wr_count <= 0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wren[b]) mem[b][ram_address[8*b +: 8]] <= ram_data[128*b +: 128];
      wr_count <= wr_count + $countones(ram_wren);
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask

  function automatic logic [127:0] pattern(input logic [3:0] p, input logic [5:0] w);
    logic [31:0] t;
    t = {16'hC0DE, 4'h0, p, 2'b00, w};
    return {t, ~t, t ^ 32'h5A5A_5A5A, {t[15:0], t[31:16]}};
  endfunction

  task automatic clear_mem();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done", done, 1'b0);
    check("start_len_err", len_err, 1'b0);
  endtask

  // Feeds nbeats words from packet 0 word 0; gap_pct is the idle chance per
  // slot, (err_p, err_w) places a misplaced in_last, start pulses at start_beat.
  task automatic run_block(input int gap_pct, input int err_p, input int err_w,
                           input int nbeats, input int start_beat);
    logic [3:0] pv;
    logic [5:0] wv;
    logic       exp_err;
    exp_err = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      pv = 4'(b >> 6);
      wv = 6'(b & 63);
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        tick();
        check("idle_wren", ram_wren, 4'b0000);
      end
      in_valid = 1'b1;
      in_data  = pattern(pv, wv);
      in_last  = (wv == 6'd63) ^ ((b >> 6) == err_p && (b & 63) == err_w);
      start    = (b == start_beat);
      check("in_ready", in_ready, 1'b1);
      tick();
      start = 1'b0;
      if (in_last != (wv == 6'd63)) exp_err = 1'b1;
      check("wren", ram_wren, 4'b0001 << pv[1:0]);
      check("addr", ram_address, {4{pv[3:2], wv}});
      check("data", ram_data, {4{pattern(pv, wv)}});
      check("len_err", len_err, exp_err);
      check("done", done, b == 1023);
      if (b == 0) begin
        check("first_wren", ram_wren, 4'b0001);
        check("first_addr", ram_address, 32'h0000_0000);
      end
      if (b == 5 * 64 + 10) begin
        check("p5w10_wren", ram_wren, 4'b0010);
        check("p5w10_addr", ram_address, 32'h4A4A_4A4A);
      end
      if (b == 1023) begin
        check("final_wren", ram_wren, 4'b1000);
        check("final_addr", ram_address, 32'hFFFF_FFFF);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_image();
    logic [3:0] pv;
    logic [5:0] wv;
    for (int b = 0; b < 1024; b++) begin
      pv = 4'(b >> 6);
      wv = 6'(b & 63);
      check("image", mem[pv[1:0]][{pv[3:2], wv}], pattern(pv, wv));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    mem_clr = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mem_clr = 1'b0;

    // Reset state, then valid without start must not be accepted.
    check("rst_wren", ram_wren, 4'b0000);
    check("rst_data", ram_data, '0);
    check("rst_addr", ram_address, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    in_valid = 1'b1;
    in_data  = {4{32'hDEAD_BEEF}};
    repeat (20) begin
      tick();
      check("idle_ready", in_ready, 1'b0);
      check("idle_wren0", ram_wren, 4'b0000);
    end
    in_valid = 1'b0;

    // Continuous block with an ignored start pulse at beat 500.
    clear_mem();
    pulse_start();
    run_block(0, -1, -1, 1024, 500);
    tick();
    check("a_busy_after", busy, 1'b0);
    check("a_done_held", done, 1'b1);
    check("a_wr_count", wr_count, 1024);
    check_image();

    // Misplaced in_last on packet 3 word 20.
    pulse_start();
    run_block(0, 3, 20, 1024, -1);
    tick();
    check("b_len_err_held", len_err, 1'b1);
    check("b_done", done, 1'b1);

    // Second start clears len_err; block with 30% idle slots.
    clear_mem();
    pulse_start();
    run_block(30, -1, -1, 1024, -1);
    tick();
    check("c_wr_count", wr_count, 1024);
    check("c_len_err", len_err, 1'b0);
    check_image();

    // Reset after 300 beats, then reload from packet 0 word 0.
    pulse_start();
    run_block(0, -1, -1, 300, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d_busy", busy, 1'b0);
    check("d_ready", in_ready, 1'b0);
    check("d_wren", ram_wren, 4'b0000);
    check("d_addr", ram_address, 32'h0);
    check("d_data", ram_data, '0);
    clear_mem();
    pulse_start();
    run_block(0, -1, -1, 1024, -1);
    tick();
    check("d_wr_count", wr_count, 1024);
    check_image();

    // rst wins over start on the same edge.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("col_busy", busy, 1'b0);
    check("col_ready", in_ready, 1'b0);
    check("col_done", done, 1'b0);
    tick();
    check("col_busy_next", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
